// File: rtl/crossbar_noc_pkg.sv
// Shared constants and types for the APB crossbar NoC completer arbiters.
package crossbar_noc_pkg;

  localparam int ADDR_W   = 60;
  localparam int DATA_W   = 32;
  localparam int NUM_REQ  = 3;
  localparam int NUM_COMP = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] REQ0 = 2'b00;
  localparam logic [1:0] REQ1 = 2'b01;
  localparam logic [1:0] REQ2 = 2'b10;

endpackage

// File: rtl/apb_rr_pick.sv
// Rotate-priority picker: first pending requester after rr_ptr_i, modulo NUM_REQ.
module apb_rr_pick
  import crossbar_noc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [GNT_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [GNT_W-1:0]   winner_o
);

  int               idx;
  logic [GNT_W-1:0] idx_g;

  // Scan from farthest to nearest so the nearest pending requester is written last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    idx_g    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx   = (int'(rr_ptr_i) + k) % NUM_REQ;
      idx_g = GNT_W'(idx);
      if (pending_i[idx_g]) begin
        valid_o  = 1'b1;
        winner_o = idx_g;
      end
    end
  end

endmodule

// File: rtl/apb_comp_arbiter.sv
// Per-completer APB arbiter: round-robin grant and SETUP/ACCESS sequencing.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_comp_arbiter
  import crossbar_noc_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 60,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int GNT_W       = $clog2(NUM_REQ)
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_psel,
  input  logic [NUM_REQ-1:0]        req_penable,
  input  logic [NUM_REQ-1:0]        req_pwrite,
  input  logic [NUM_REQ*ADDR_W-1:0] req_paddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_pwdata,
  output logic [NUM_REQ-1:0]        req_pready,
  output logic [DATA_W-1:0]         req_prdata,
  output logic                      req_pslverr,
  output logic                      m_psel,
  output logic                      m_penable,
  output logic                      m_pwrite,
  output logic [ADDR_W-1:0]         m_paddr,
  output logic [DATA_W-1:0]         m_pwdata,
  input  logic                      m_pready,
  input  logic [DATA_W-1:0]         m_prdata,
  input  logic                      m_pslverr,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy
);

  arb_state_e          state_q, state_d;
  logic [GNT_W-1:0]    g_q, g_d, rr_q, rr_d;
  logic                m_psel_q, m_psel_d, m_penable_q, m_penable_d, m_pwrite_q, m_pwrite_d;
  logic [ADDR_W-1:0]   m_paddr_q, m_paddr_d;
  logic [DATA_W-1:0]   m_pwdata_q, m_pwdata_d, prdata_q, prdata_d;
  logic [NUM_REQ-1:0]  pready_q, pready_d;
  logic                pslverr_q, pslverr_d, busy_q;
  logic                pick_valid, xfer_done, timeout;
  logic [GNT_W-1:0]    pick_winner;
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic                unused_penable;

  // Requester enable carries no information beyond psel for arbitration.
  assign unused_penable = ^req_penable;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_arr[i]  = req_paddr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_pwdata[i*DATA_W +: DATA_W];
  end

  apb_rr_pick #(.NUM_REQ(NUM_REQ), .GNT_W(GNT_W)) u_pick (
    .pending_i (req_psel),
    .rr_ptr_i  (rr_q),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  // m_pready only counts once the completer actually sees penable.
  assign xfer_done = (state_q == ACCESS) && m_penable_q && m_pready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                                cnt_q <= '0;
    else if (state_q == SETUP)                 cnt_q <= '0;
    else if (state_q == ACCESS && !xfer_done)  cnt_q <= cnt_q + 1'b1;
  end

  assign timeout = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_d        = rr_q;
    m_pwrite_d  = m_pwrite_q;
    m_paddr_d   = m_paddr_q;
    m_pwdata_d  = m_pwdata_q;
    m_psel_d    = 1'b0;
    m_penable_d = 1'b0;
    pready_d    = '0;
    prdata_d    = '0;
    pslverr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          g_d        = pick_winner;
          rr_d       = pick_winner;
          m_pwrite_d = req_pwrite[pick_winner];
          m_paddr_d  = addr_arr[pick_winner];
          m_pwdata_d = wdata_arr[pick_winner];
          state_d    = SETUP;
        end
      end
      SETUP: begin
        m_psel_d = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (xfer_done) begin
          state_d     = RESP;
          pready_d[g_q] = 1'b1;
          prdata_d    = m_pwrite_q ? '0 : m_prdata;
          pslverr_d   = m_pslverr;
        end else if (timeout) begin
          state_d     = RESP;
          pready_d[g_q] = 1'b1;
          pslverr_d   = 1'b1;
        end else begin
          m_psel_d    = 1'b1;
          m_penable_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_q        <= GNT_W'(NUM_REQ - 1);
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      pready_q    <= '0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_q        <= rr_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      m_pwrite_q  <= m_pwrite_d;
      m_paddr_q   <= m_paddr_d;
      m_pwdata_q  <= m_pwdata_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_pready  = pready_q;
  assign req_prdata  = prdata_q;
  assign req_pslverr = pslverr_q;
  assign m_psel      = m_psel_q;
  assign m_penable   = m_penable_q;
  assign m_pwrite    = m_pwrite_q;
  assign m_paddr     = m_paddr_q;
  assign m_pwdata    = m_pwdata_q;
  assign grant_id    = g_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_apb_comp_arbiter.sv
// Directed self-checking bench for apb_comp_arbiter (timeout section needs APB_ARB_TIMEOUT_EN).
module tb_apb_comp_arbiter;

  localparam int NR = 3;
  localparam int AW = 60;
  localparam int DW = 32;
  localparam int GW = 2;

  logic              pclk = 1'b0;
  logic              preset;
  logic [NR-1:0]     req_psel, req_penable, req_pwrite;
  logic [NR*AW-1:0]  req_paddr;
  logic [NR*DW-1:0]  req_pwdata;
  logic [NR-1:0]     req_pready;
  logic [DW-1:0]     req_prdata;
  logic              req_pslverr;
  logic              m_psel, m_penable, m_pwrite;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic              m_pready;
  logic [DW-1:0]     m_prdata;
  logic              m_pslverr;
  logic [GW-1:0]     grant_id;
  logic              busy;

  apb_comp_arbiter dut (
    .pclk(pclk), .preset(preset),
    .req_psel(req_psel), .req_penable(req_penable), .req_pwrite(req_pwrite),
    .req_paddr(req_paddr), .req_pwdata(req_pwdata),
    .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 pclk = ~pclk;
  assign req_penable = req_psel;

  int n_cmp = 0;
  int n_fail = 0;

  // completer model knobs
  int            comp_wait = 0;
  bit            comp_never = 1'b0;
  logic [DW-1:0] comp_rdata = '0;
  bit            comp_err = 1'b0;
  int            waited = 0;

  // observation
  int            pulse_id[$];
  logic [DW-1:0] pulse_rdata[$];
  bit            pulse_err[$];
  int            reissue[NR];
  int            onehot_err = 0;
  int            unstable = 0;
  bit            acc_seen = 1'b0;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_write;

  typedef struct {
    int            id;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
    int            waits;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_paddr[i*AW +: AW]  = a;
    req_pwdata[i*DW +: DW] = d;
    req_pwrite[i]          = wr;
    req_psel[i]            = 1'b1;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string nm);
    for (int c = 0; c < budget && pulse_id.size() < target; c++) tick();
    check({nm, "_pulse_count"}, 64'(pulse_id.size()), 64'(target));
  endtask

  task automatic do_reset();
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
    tick();
  endtask

  // completer model, requester pready handling and bus stability monitor
  initial begin
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    for (int i = 0; i < NR; i++) reissue[i] = 0;
    forever begin
      @(negedge pclk);
      if (m_psel && !preset) begin
        if (!acc_seen) begin
          acc_addr = m_paddr; acc_wdata = m_pwdata; acc_write = m_pwrite;
        end else if (m_paddr !== acc_addr || m_pwdata !== acc_wdata || m_pwrite !== acc_write) begin
          unstable++;
        end
        acc_seen = 1'b1;
        if (m_penable && !comp_never && waited >= comp_wait) begin
          m_pready = 1'b1; m_prdata = comp_rdata; m_pslverr = comp_err;
        end else begin
          m_pready = 1'b0;
          if (m_penable) waited++;
        end
      end else begin
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        waited = 0; acc_seen = 1'b0;
      end
      if (req_pready != '0) begin
        if ($countones(req_pready) != 1) onehot_err++;
        for (int i = 0; i < NR; i++) begin
          if (req_pready[i]) begin
            pulse_id.push_back(i);
            pulse_rdata.push_back(req_prdata);
            pulse_err.push_back(req_pslverr);
            if (reissue[i] > 0) reissue[i]--;
            else req_psel[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;

    vecs[0] = '{1, 1'b0, 60'h0_0000_1000_0004, 32'h0000_0000, 32'h1111_2222, 1'b0, 0, 32'h1111_2222, 1'b0};
    vecs[1] = '{2, 1'b1, 60'hA_BCDE_F012_3456, 32'hA5A5_5A5A, 32'h9999_9999, 1'b0, 2, 32'h0000_0000, 1'b0};
    vecs[2] = '{0, 1'b0, 60'h1_0000_0000_0010, 32'h0000_0001, 32'h0BAD_F00D, 1'b1, 1, 32'h0BAD_F00D, 1'b1};
    vecs[3] = '{2, 1'b0, 60'hF_FFFF_FFFF_FFFC, 32'h0000_0002, 32'h1234_5678, 1'b0, 3, 32'h1234_5678, 1'b0};
    vecs[4] = '{1, 1'b1, 60'h0_0000_0000_0000, 32'hFFFF_0000, 32'h7777_7777, 1'b1, 0, 32'h0000_0000, 1'b1};

    preset = 1'b1;
    req_psel = '0; req_pwrite = '0; req_paddr = '0; req_pwdata = '0;
    tick();
    check("rst_m_psel", 64'(m_psel), 64'd0);
    check("rst_m_penable", 64'(m_penable), 64'd0);
    check("rst_req_pready", 64'(req_pready), 64'd0);
    check("rst_req_prdata", 64'(req_prdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_m_paddr", 64'(m_paddr), 64'd0);
    tick();
    preset = 1'b0;
    tick();

    // single zero-wait write, edge-by-edge timing
    comp_wait = 0; comp_rdata = 32'h5555_5555; comp_err = 1'b0;
    issue(0, 1'b1, 60'h0_1234_ABCD_0000, 32'hDEAD_BEEF);
    tick();
    check("t1_e1_m_psel", 64'(m_psel), 64'd0);
    check("t1_e1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_e2_m_psel", 64'(m_psel), 64'd1);
    check("t1_e2_m_penable", 64'(m_penable), 64'd0);
    check("t1_e2_m_paddr", 64'(m_paddr), 64'h0_1234_ABCD_0000);
    check("t1_e2_m_pwdata", 64'(m_pwdata), 64'hDEAD_BEEF);
    check("t1_e2_m_pwrite", 64'(m_pwrite), 64'd1);
    tick();
    check("t1_e3_m_penable", 64'(m_penable), 64'd1);
    check("t1_e3_req_pready", 64'(req_pready), 64'd0);
    tick();
    check("t1_e4_req_pready", 64'(req_pready), 64'b001);
    check("t1_e4_pslverr", 64'(req_pslverr), 64'd0);
    check("t1_e4_prdata", 64'(req_prdata), 64'd0);
    check("t1_e4_m_psel", 64'(m_psel), 64'd0);
    tick();
    check("t1_e5_req_pready", 64'(req_pready), 64'd0);
    check("t1_e5_busy", 64'(busy), 64'd0);
    tick();

    // table of single transfers
    for (int v = 0; v < 5; v++) begin
      comp_wait = vecs[v].waits; comp_rdata = vecs[v].rdata; comp_err = vecs[v].err;
      base = pulse_id.size();
      issue(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      wait_pulses(base + 1, 60, $sformatf("vec%0d", v));
      if (pulse_id.size() > base) begin
        check($sformatf("vec%0d_id", v), 64'(pulse_id[base]), 64'(vecs[v].id));
        check($sformatf("vec%0d_prdata", v), 64'(pulse_rdata[base]), 64'(vecs[v].exp_rdata));
        check($sformatf("vec%0d_pslverr", v), 64'(pulse_err[base]), 64'(vecs[v].exp_err));
      end
      check($sformatf("vec%0d_m_paddr", v), 64'(acc_addr), 64'(vecs[v].addr));
      check($sformatf("vec%0d_m_pwdata", v), 64'(acc_wdata), 64'(vecs[v].wdata));
      check($sformatf("vec%0d_m_pwrite", v), 64'(acc_write), 64'(vecs[v].wr));
      check($sformatf("vec%0d_grant_id", v), 64'(grant_id), 64'(vecs[v].id));
      tick(); tick();
    end

    // same-cycle contention after reset: order 0,1,2
    do_reset();
    comp_wait = 0; comp_rdata = 32'hCAFE_F00D; comp_err = 1'b0;
    base = pulse_id.size();
    issue(0, 1'b1, 60'h0_0000_0000_0100, 32'h0000_00A0);
    issue(1, 1'b0, 60'h0_0000_0000_0104, 32'h0000_00A1);
    issue(2, 1'b1, 60'h0_0000_0000_0108, 32'h0000_00A2);
    wait_pulses(base + 3, 60, "cont");
    if (pulse_id.size() >= base + 3) begin
      for (int k = 0; k < 3; k++)
        check($sformatf("cont_order%0d", k), 64'(pulse_id[base+k]), 64'(k));
      check("cont_req0_prdata", 64'(pulse_rdata[base]), 64'd0);
      check("cont_req1_prdata", 64'(pulse_rdata[base+1]), 64'hCAFE_F00D);
      check("cont_req2_prdata", 64'(pulse_rdata[base+2]), 64'd0);
    end
    tick(); tick();

    // fairness: req0 back-to-back x4, req2 x2, rr_ptr currently at 2
    base = pulse_id.size();
    reissue[0] = 3; reissue[2] = 1;
    issue(0, 1'b1, 60'h0_0000_0000_0200, 32'h0000_00B0);
    issue(2, 1'b0, 60'h0_0000_0000_0208, 32'h0000_00B2);
    wait_pulses(base + 6, 100, "fair");
    if (pulse_id.size() >= base + 6) begin
      int exp_ord[6] = '{0, 2, 0, 2, 0, 0};
      for (int k = 0; k < 6; k++)
        check($sformatf("fair_order%0d", k), 64'(pulse_id[base+k]), 64'(exp_ord[k]));
    end
    tick(); tick();

    // wait states plus error; granted requester changes its slice mid-transfer
    comp_wait = 5; comp_rdata = 32'h2468_ACE0; comp_err = 1'b1;
    unstable = 0;
    base = pulse_id.size();
    issue(1, 1'b0, 60'h3_0000_0000_0040, 32'h0000_0011);
    tick();
    issue(0, 1'b1, 60'h3_0000_0000_0080, 32'h0000_0022);
    tick(); tick(); tick();
    req_paddr[1*AW +: AW] = 60'h7_7777_7777_7777;
    req_pwdata[1*DW +: DW] = 32'h7777_7777;
    wait_pulses(base + 1, 60, "ws_first");
    if (pulse_id.size() > base) begin
      check("ws_first_id", 64'(pulse_id[base]), 64'd1);
      check("ws_pslverr", 64'(pulse_err[base]), 64'd1);
      check("ws_prdata", 64'(pulse_rdata[base]), 64'h2468_ACE0);
    end
    check("ws_acc_addr", 64'(acc_addr), 64'h3_0000_0000_0040);
    comp_wait = 0; comp_err = 1'b0;
    wait_pulses(base + 2, 60, "ws_second");
    if (pulse_id.size() > base + 1)
      check("ws_second_id", 64'(pulse_id[base+1]), 64'd0);
    check("ws_stable", 64'(unstable), 64'd0);
    tick(); tick();

    // reset during ACCESS
    comp_wait = 20; comp_rdata = 32'h1357_9BDF;
    base = pulse_id.size();
    issue(2, 1'b0, 60'h5_0000_0000_0000, 32'h0);
    cnt = 0;
    while (!m_penable && cnt < 20) begin tick(); cnt++; end
    check("rstm_reached_access", 64'(m_penable), 64'd1);
    tick(); tick();
    preset = 1'b1;
    #1;
    check("rstm_m_psel", 64'(m_psel), 64'd0);
    check("rstm_m_penable", 64'(m_penable), 64'd0);
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_m_paddr", 64'(m_paddr), 64'd0);
    check("rstm_req_pready", 64'(req_pready), 64'd0);
    tick(); tick();
    check("rstm_no_pulse", 64'(pulse_id.size()), 64'(base));
    comp_wait = 0;
    issue(0, 1'b1, 60'h5_0000_0000_0010, 32'h0000_00C0);
    preset = 1'b0;
    wait_pulses(base + 2, 60, "rstm");
    if (pulse_id.size() >= base + 2) begin
      check("rstm_first_grant", 64'(pulse_id[base]), 64'd0);
      check("rstm_second_grant", 64'(pulse_id[base+1]), 64'd2);
    end
    tick(); tick();

`ifdef APB_ARB_TIMEOUT_EN
    do_reset();
    comp_never = 1'b1; comp_rdata = 32'hFFFF_FFFF; comp_err = 1'b0;
    base = pulse_id.size();
    issue(0, 1'b0, 60'h9_0000_0000_0000, 32'h0);
    issue(1, 1'b0, 60'h9_0000_0000_0004, 32'h0);
    cnt = 0;
    while (!m_psel && cnt < 10) begin tick(); cnt++; end
    cnt = 0;
    while (m_psel && cnt < 40) begin cnt++; tick(); end
    check("to_access_cycles", 64'(cnt), 64'd16);
    wait_pulses(base + 1, 10, "to_first");
    comp_never = 1'b0;
    if (pulse_id.size() > base) begin
      check("to_id", 64'(pulse_id[base]), 64'd0);
      check("to_pslverr", 64'(pulse_err[base]), 64'd1);
      check("to_prdata", 64'(pulse_rdata[base]), 64'd0);
    end
    wait_pulses(base + 2, 60, "to_next");
    if (pulse_id.size() > base + 1)
      check("to_next_id", 64'(pulse_id[base+1]), 64'd1);
    tick(); tick();
`endif

    check("onehot_pready", 64'(onehot_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_comp_arbiter.md
Name: apb_comp_arbiter

Overview:
Per-completer arbiter for the APB crossbar NoC. One instance sits in front of each completer port. It shares that completer among NUM_REQ requesters (masters 2'b00, 2'b01, 2'b10) using round-robin grant, and sequences the APB SETUP/ACCESS phases toward the completer. It routes pready, prdata and pslverr back only to the granted requester; non-granted requesters stall in their ACCESS phase.

Parameters:
NUM_REQ, 3, number of requester ports
ADDR_W, 60, address width ({28-bit high, 32-bit low})
DATA_W, 32, data width
TIMEOUT_CYC, 16, ACCESS-phase watchdog limit; used only when APB_ARB_TIMEOUT_EN is defined
GNT_W, $clog2(NUM_REQ), grant index width (derived)

Ports:
pclk  in  1  APB clock
preset  in  1  asynchronous active-high reset
req_psel  in  NUM_REQ  per-requester select (already decoded for this completer)
req_penable  in  NUM_REQ  per-requester enable
req_pwrite  in  NUM_REQ  per-requester write(1)/read(0)
req_paddr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice i
req_pwdata  in  NUM_REQ*DATA_W  flattened write data
req_pready  out  NUM_REQ  one-hot completion pulse
req_prdata  out  DATA_W  shared read data; valid only with req_pready
req_pslverr  out  1  shared error; valid only with req_pready
m_psel  out  1  completer select
m_penable  out  1  completer enable
m_pwrite  out  1  completer direction
m_paddr  out  ADDR_W  completer address
m_pwdata  out  DATA_W  completer write data
m_pready  in  1  completer ready
m_prdata  in  DATA_W  completer read data
m_pslverr  in  1  completer error
grant_id  out  GNT_W  current/last granted requester (debug)
busy  out  1  high whenever state is not IDLE

Behaviour:
- One clock domain (pclk). Reset is asynchronous, active-high (preset).
- Reset values: all outputs 0; FSM in IDLE; rr_ptr = NUM_REQ-1, so requester 0 has top priority first.
- A requester is "pending" while req_psel[i]=1, in either its setup or access phase.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any request is pending, pick the first pending requester scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register g = winner and rr_ptr = g. Latch paddr, pwdata and pwrite from slice g into m_* registers.
  - Next state SETUP. If nothing is pending, stay in IDLE.
- SETUP: m_psel=1, m_penable=0; next state ACCESS unconditionally.
- ACCESS:
  - m_psel=1, m_penable=1.
  - When m_pready=1: capture m_prdata and m_pslverr, drop m_psel/m_penable on the next edge, go to RESP.
  - Otherwise hold; m_* address, data and direction stay stable.
- RESP:
  - req_pready[g]=1 for exactly one cycle; req_prdata and req_pslverr hold the captured values.
  - Next state IDLE.
- Registered outputs only. For an uncontended zero-wait completer, req_pready rises 4 edges after the first edge sampling req_psel.
- Outside RESP: req_pready=0 and req_prdata=0; req_pslverr follows the same rule.
- Requests that change while not granted are not observed; only the values present at the IDLE grant edge are forwarded.
- A requester that issues a back-to-back transfer (psel stays high after its pready) is re-arbitrated normally. Rotation guarantees other pending requesters are served first.
- Simultaneous arrival: all arrivals in the same cycle are served in rotation order. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-transfer: all outputs clear immediately. The in-flight transfer is abandoned with no pready to any requester.
- m_prdata is captured on reads only; on writes, req_prdata=0.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to ACCESS and increments each ACCESS cycle without m_pready.
  - When the counter reaches TIMEOUT_CYC: drop m_psel/m_penable and go to RESP with req_pslverr=1 and req_prdata=0.
  - A late m_pready after the timeout is ignored.
- Undefined: no counter is built; ACCESS waits indefinitely; TIMEOUT_CYC is unused.

Decomposition:
- crossbar_noc_pkg holds:
  - the ADDR_W, DATA_W, NUM_REQ and NUM_COMP constants
  - the arb_state_e enum {IDLE, SETUP, ACCESS, RESP}
  - the requester ID constants REQ0=2'b00, REQ1=2'b01, REQ2=2'b10
- One sub-module, apb_rr_pick: combinational rotate-priority picker.
  - Inputs: pending vector, rr_ptr.
  - Outputs: valid, winner index.
  - Instantiated once; the FSM and capture registers stay in apb_comp_arbiter.

Test Plan:
- Single write, zero-wait: req0 writes addr 60'h0_1234_ABCD_0000, data 32'hDEADBEEF. Expect:
  - m_psel on edge 2, m_penable on edge 3, m_paddr/m_pwdata matching.
  - req_pready[0] pulse on edge 4 with pslverr=0.
- Same-cycle contention: req0 (write), req1 (read) and req2 (write) all assert psel in one cycle. Expect:
  - grant order 0, 1, 2, with exactly one req_pready pulse each.
  - req1 receives m_prdata=32'hCAFEF00D.
- Fairness: req0 re-requests back-to-back while req2 is pending. Expect grant sequence 0, 2, 0, with no starvation over 6 transfers.
- Wait states plus error: completer holds m_pready low 5 cycles, then returns m_pslverr=1. Expect:
  - m_* stable throughout ACCESS; req_pready pulses once, with req_pslverr=1.
  - waiting requesters' req_pready stays 0.
- Reset during ACCESS: assert preset mid-wait. Expect:
  - all outputs 0 the same cycle, no pready pulse.
  - after release, the first grant goes to req0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: completer never readies. Expect:
  - m_psel drops after 16 ACCESS cycles.
  - req_pready pulse with req_pslverr=1 and req_prdata=0.
  - the next pending requester is then granted.
